id_scoreboard: RTL and testbench
================================

// Module: id_scoreboard
// PURPOSE
//  Parametrised operand-readiness, bypass and interlock unit for the ID stage. Per-register latency
//  counters replace the single-cycle "previous inst is load" check, so multi-cycle producers stall correctly.
//  Selects the youngest of NFWD forwarding channels for each operand.
//  Holds the fetched instruction across any stall, keeping inst aligned with its pc.
//  Sits between inst_sram_rdata/regfile and the decode/branch logic of ID.
// PARAMETERS
//  AW      5   register address width; NREG = 2**AW, register 0 hard-wired zero
//  DW      32  data width
//  NFWD    3   forwarding channels; index 0 = youngest (EX), NFWD-1 = oldest (WB)
//  MAXLAT  3   largest producer latency in cycles; counter width CW = $clog2(MAXLAT+1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active high
//  stall_ext    in   1          stall of ID from downstream (stall[2]) or a cache miss
//  flush        in   1          kill the instruction in ID this cycle: no issue, hold cleared
//  inst_in      in   DW         raw instruction from inst_sram_rdata
//  inst_out     out  DW         instruction to decode: hold_v ? hold_q : inst_in
//  raddr1       in   AW         rs address
//  raddr2       in   AW         rt address
//  use1         in   1          decoded inst reads raddr1
//  use2         in   1          decoded inst reads raddr2
//  rf_rdata1    in   DW         regfile read data for raddr1
//  rf_rdata2    in   DW         regfile read data for raddr2
//  fwd_valid    in   NFWD       channel i carries final result data this cycle
//  fwd_waddr    in   NFWD*AW    channel i destination, channel i at [i*AW +: AW]
//  fwd_wdata    in   NFWD*DW    channel i data, channel i at [i*DW +: DW]
//  issue_valid  in   1          ID holds a real instruction (ce)
//  issue_we     in   1          instruction writes the register file
//  issue_waddr  in   AW         destination register
//  issue_lat    in   CW         cycles until regfile read returns the result (ALU 3, load 4 clipped to MAXLAT)
//  rdata1       out  DW         bypassed operand 1
//  rdata2       out  DW         bypassed operand 2
//  stallreq     out  1          interlock request, feeds stallreq_for_id
// BEHAVIOUR
//  - Reset: all cnt[r]=0, hold_v=0. So stallreq=0, inst_out=inst_in and rdataN=rf_rdataN until a hit.
//  - issue_fire = issue_valid & ~stallreq & ~stall_ext & ~flush.
//  - Counters, per r != 0, evaluated each cycle:
//      1. issue_fire & issue_we & issue_waddr==r: cnt[r] <= issue_lat. Issue wins over decrement.
//      2. else if cnt[r] != 0: cnt[r] <= cnt[r]-1.
//  - cnt[0] is always 0. Writes to r0 never set pending and never forward.
//  - Bypass for operand k: hit_i = fwd_valid[i] & fwd_waddr_i==raddrk & raddrk!=0.
//      rdatak = data of the lowest-index hit, else rf_rdatak. Priority is combinational, no added latency.
//  - busyk = usek & cnt[raddrk]!=0 & no hit.
//      busyk means the producer is in flight and has no data yet (load in EX, multi-cycle op).
//  - stallreq = (busy1 | busy2) & issue_valid. Combinational. Drops in the same cycle the data appears on a channel.
//  - Instruction hold:
//      - capture hold_q <= inst_in and set hold_v when (stallreq | stall_ext) & ~hold_v.
//      - clear hold_v when the stall condition is low (instruction advances) or on flush.
//      - hold_q never changes while hold_v = 1.
//  - Same-cycle issue and read of one register:
//      - the reader sees the counter value before the update; the new dependency applies to the next instruction.
//  - Flush mid-stall: hold cleared, nothing issued. Counters already set keep counting, since issued producers still write.
//  - Reset mid-operation: all counters and hold cleared at the next edge regardless of other inputs.
//  - issue_lat=0 from a zero-latency producer: no pending state is set.
// STRUCTURE
//  - Shared package/defines.vh: `FWD_EX/`FWD_MEM/`FWD_WB channel indices, LAT_ALU/LAT_LOAD constants,
//    and the channel bus layout {we, waddr[AW-1:0], wdata[DW-1:0]}, matching ex_to_id_bus.
//  - One sub-module, fwd_select: NFWD-way priority bypass mux. Instantiated twice, once per operand.
//  - Counter array, busy logic and inst hold stay in the top module.
// TESTING
//  1. lw $2 issued (lat 3); next inst addu $3,$2,$4 -> stallreq=1 for cycles with cnt[2]!=0 and no hit.
//     Releases the cycle fwd_valid[1]=1 with waddr=2; rdata1=fwd_wdata1.
//  2. EX(ch0) and WB(ch2) both write $5: 0xAAAA and 0x5555; reader of $5 -> rdata=0xAAAA, stallreq=0.
//  3. Stall raised while inst_in=0x8C820004, then inst_in changes to 0xDEADBEEF.
//     inst_out stays 0x8C820004 until the stall drops, then follows inst_in.
//  4. Write to $0 with lat 3, fwd_valid on waddr=0 with data 0x1234; reader of $0 -> rdata=rf_rdata (0), no stall.
//  5. Flush while the hold is valid and cnt[7]=2 -> hold_v=0 next cycle, cnt[7]=1, no issue recorded.
//  6. rst asserted with cnt[9]=3 and hold_v=1 -> next cycle all cnt=0, hold_v=0, stallreq=0.

Source files
------------

// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg
//   Shared definitions for the ID-stage operand scoreboard.
//   - fwd_ch_e   : forwarding channel indices, youngest (EX) at index 0
//   - lat_e      : producer latencies as seen by the ID stage
//   - fwd_bus_w  : width of one {we, waddr, wdata} channel bus, matching ex_to_id_bus
//   - clip_lat   : clip a producer latency to what the counters can hold
package id_scoreboard_pkg;

  typedef enum int {
    FWD_EX  = 0,
    FWD_MEM = 1,
    FWD_WB  = 2
  } fwd_ch_e;

  typedef enum int {
    LAT_NONE = 0,
    LAT_ALU  = 3,
    LAT_LOAD = 4
  } lat_e;

  // One channel bus is laid out as {we, waddr[aw-1:0], wdata[dw-1:0]}.
  function automatic int fwd_bus_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  // Loads nominally need 4 cycles; counters saturate at maxlat.
  function automatic int clip_lat(input int lat, input int maxlat);
    return (lat > maxlat) ? maxlat : lat;
  endfunction

endpackage

// File: rtl/id_scoreboard_fwd_select.sv
// id_scoreboard_fwd_select
//   NFWD-way priority bypass mux for one source operand. The lowest-index
//   (youngest) channel whose destination matches raddr wins; register 0
//   never matches. Purely combinational.
// Ports
//   raddr      in   AW        operand register address
//   fwd_valid  in   NFWD      channel i carries final result data
//   fwd_waddr  in   NFWD*AW   channel i destination at [i*AW +: AW]
//   fwd_wdata  in   NFWD*DW   channel i data at [i*DW +: DW]
//   rf_rdata   in   DW        regfile read data, used when no channel hits
//   rdata      out  DW        bypassed operand
//   hit        out  1         some channel supplied the operand
module id_scoreboard_fwd_select
  import id_scoreboard_pkg::*;
#(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]      raddr,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  input  logic [DW-1:0]      rf_rdata,
  output logic [DW-1:0]      rdata,
  output logic               hit
);

  // Walk from oldest to youngest so the youngest matching channel is the
  // last assignment and therefore wins.
  always_comb begin
    rdata = rf_rdata;
    hit   = 1'b0;
    for (int i = NFWD - 1; i >= int'(FWD_EX); i--) begin
      if (fwd_valid[i] && (fwd_waddr[i*AW +: AW] == raddr) && (raddr != '0)) begin
        rdata = fwd_wdata[i*DW +: DW];
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard
//   Operand readiness, bypass and interlock unit for the ID stage.
//   A per-register latency counter tracks how many cycles remain until an
//   in-flight producer's result reaches the register file. An operand whose
//   counter is non-zero and which no forwarding channel supplies is busy and
//   raises stallreq. The fetched instruction is held across any stall so
//   inst_out stays aligned with its pc.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   stall_ext              downstream stall or cache miss
//   flush                  kill the instruction in ID, clear the hold
//   inst_in / inst_out     raw fetched instruction / instruction to decode
//   raddr1/2, use1/2       operand addresses and whether they are read
//   rf_rdata1/2            regfile read data
//   fwd_valid/waddr/wdata  NFWD forwarding channels, index 0 youngest
//   issue_valid/we/waddr   instruction in ID and its destination
//   issue_lat              cycles until the result is readable from the regfile
//   rdata1/2               bypassed operands
//   stallreq               interlock request
//
// Handshake: issue_valid is the ID instruction's valid; it is accepted
// (issue_fire) only when neither stallreq nor stall_ext holds it and it is
// not flushed. Only an accepted instruction records a pending destination.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter  int AW     = 5,
  parameter  int DW     = 32,
  parameter  int NFWD   = 3,
  parameter  int MAXLAT = 3,
  localparam int CW     = $clog2(MAXLAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ext,
  input  logic               flush,
  input  logic [DW-1:0]      inst_in,
  output logic [DW-1:0]      inst_out,
  input  logic [AW-1:0]      raddr1,
  input  logic [AW-1:0]      raddr2,
  input  logic               use1,
  input  logic               use2,
  input  logic [DW-1:0]      rf_rdata1,
  input  logic [DW-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  input  logic               issue_valid,
  input  logic               issue_we,
  input  logic [AW-1:0]      issue_waddr,
  input  logic [CW-1:0]      issue_lat,
  output logic [DW-1:0]      rdata1,
  output logic [DW-1:0]      rdata2,
  output logic               stallreq
);

  localparam int NREG = 2 ** AW;

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic          hold_v_q, hold_v_d;
  logic [DW-1:0] hold_inst_q, hold_inst_d;

  logic hit1, hit2;
  logic busy1, busy2;
  logic stall_any;
  logic issue_fire;

  // ---------------------------------------------------------------------
  // Bypass muxes, one per operand
  // ---------------------------------------------------------------------
  id_scoreboard_fwd_select #(
    .AW  (AW),
    .DW  (DW),
    .NFWD(NFWD)
  ) u_fwd1 (
    .raddr    (raddr1),
    .fwd_valid(fwd_valid),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .rf_rdata (rf_rdata1),
    .rdata    (rdata1),
    .hit      (hit1)
  );

  id_scoreboard_fwd_select #(
    .AW  (AW),
    .DW  (DW),
    .NFWD(NFWD)
  ) u_fwd2 (
    .raddr    (raddr2),
    .fwd_valid(fwd_valid),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .rf_rdata (rf_rdata2),
    .rdata    (rdata2),
    .hit      (hit2)
  );

  // ---------------------------------------------------------------------
  // Interlock. Busy uses the counter value before this cycle's update, so
  // an instruction issuing to the register it reads does not stall itself.
  // A hit on any channel means the data exists now, so the stall drops in
  // the same cycle the result appears.
  // ---------------------------------------------------------------------
  always_comb begin
    busy1      = use1 && (cnt_q[raddr1] != '0) && !hit1;
    busy2      = use2 && (cnt_q[raddr2] != '0) && !hit2;
    stallreq   = (busy1 || busy2) && issue_valid;
    stall_any  = stallreq || stall_ext;
    issue_fire = issue_valid && !stallreq && !stall_ext && !flush;
  end

  // ---------------------------------------------------------------------
  // Latency counters. A new issue overrides any count in progress; r0 is
  // never pending. Flush only blocks new issues: producers already in
  // flight still write back, so their counters keep running.
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue_fire && issue_we && (issue_waddr == AW'(r))) begin
        cnt_d[r] = issue_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Instruction hold. Capture on the first stalled cycle only, so the held
  // word is the one that was presented when the stall began even if the
  // instruction SRAM output moves on. Release when the stall goes away.
  // ---------------------------------------------------------------------
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_inst_d = hold_inst_q;
    if (flush) begin
      hold_v_d = 1'b0;
    end else if (stall_any) begin
      if (!hold_v_q) begin
        hold_v_d    = 1'b1;
        hold_inst_d = inst_in;
      end
    end else begin
      hold_v_d = 1'b0;
    end
  end

  assign inst_out = hold_v_q ? hold_inst_q : inst_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      hold_v_q    <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      hold_v_q    <= hold_v_d;
      hold_inst_q <= hold_inst_d;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard
//   Scoreboard bench for id_scoreboard: the driver applies one input vector
//   per cycle, a reference model predicts the combinational outputs and
//   pushes them into exp_q, and a monitor on the falling edge pops and
//   compares. Directed scenarios come first, then randomized traffic.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NFWD   = 3;
  localparam int MAXLAT = 3;
  localparam int CW     = 2;
  localparam int NREG   = 32;
  localparam int EW     = 3 * DW + 1;

  logic               clk;
  logic               rst;
  logic               stall_ext;
  logic               flush;
  logic [DW-1:0]      inst_in;
  logic [DW-1:0]      inst_out;
  logic [AW-1:0]      raddr1, raddr2;
  logic               use1, use2;
  logic [DW-1:0]      rf_rdata1, rf_rdata2;
  logic [NFWD-1:0]    fwd_valid;
  logic [NFWD*AW-1:0] fwd_waddr;
  logic [NFWD*DW-1:0] fwd_wdata;
  logic               issue_valid;
  logic               issue_we;
  logic [AW-1:0]      issue_waddr;
  logic [CW-1:0]      issue_lat;
  logic [DW-1:0]      rdata1, rdata2;
  logic               stallreq;

  int total;
  int bad;

  logic [EW-1:0] exp_q[$];

  // Reference model state: cycles remaining per register, and the held word.
  int            pend [NREG];
  bit            m_hold_v;
  logic [DW-1:0] m_hold_inst;

  id_scoreboard #(
    .AW    (AW),
    .DW    (DW),
    .NFWD  (NFWD),
    .MAXLAT(MAXLAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_ext  (stall_ext),
    .flush      (flush),
    .inst_in    (inst_in),
    .inst_out   (inst_out),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .use1       (use1),
    .use2       (use2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .fwd_valid  (fwd_valid),
    .fwd_waddr  (fwd_waddr),
    .fwd_wdata  (fwd_wdata),
    .issue_valid(issue_valid),
    .issue_we   (issue_we),
    .issue_waddr(issue_waddr),
    .issue_lat  (issue_lat),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .stallreq   (stallreq)
  );

  // ---------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic void model_operand(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                        output logic [DW-1:0] d, output bit hit);
    d   = rf;
    hit = 1'b0;
    if (a != 0) begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fwd_valid[i] && (fwd_waddr[i*AW +: AW] == a)) begin
          hit = 1'b1;
          d   = fwd_wdata[i*DW +: DW];
        end
      end
    end
  endfunction

  function automatic bit model_stall();
    logic [DW-1:0] d;
    bit h1, h2, b1, b2;
    model_operand(raddr1, rf_rdata1, d, h1);
    model_operand(raddr2, rf_rdata2, d, h2);
    b1 = use1 && (pend[raddr1] > 0) && !h1;
    b2 = use2 && (pend[raddr2] > 0) && !h2;
    return (b1 || b2) && issue_valid;
  endfunction

  function automatic logic [EW-1:0] model_expect();
    logic [DW-1:0] d1, d2, io;
    bit h;
    model_operand(raddr1, rf_rdata1, d1, h);
    model_operand(raddr2, rf_rdata2, d2, h);
    io = m_hold_v ? m_hold_inst : inst_in;
    return {io, d1, d2, model_stall()};
  endfunction

  // Advance the model by one clock edge using the inputs of this cycle.
  function automatic void model_clock();
    bit st, fire;
    st = model_stall();
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] = 0;
      m_hold_v = 1'b0;
    end else begin
      fire = issue_valid && !st && !stall_ext && !flush;
      for (int r = 0; r < NREG; r++) begin
        if (fire && issue_we && (int'(issue_waddr) == r) && (r != 0)) pend[r] = int'(issue_lat);
        else if (pend[r] > 0) pend[r] = pend[r] - 1;
      end
      if (flush) begin
        m_hold_v = 1'b0;
      end else if (st || stall_ext) begin
        if (!m_hold_v) begin
          m_hold_v    = 1'b1;
          m_hold_inst = inst_in;
        end
      end else begin
        m_hold_v = 1'b0;
      end
    end
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic set_idle();
    stall_ext   = 1'b0;
    flush       = 1'b0;
    raddr1      = '0;
    raddr2      = '0;
    use1        = 1'b0;
    use2        = 1'b0;
    rf_rdata1   = '0;
    rf_rdata2   = '0;
    fwd_valid   = '0;
    fwd_waddr   = '0;
    fwd_wdata   = '0;
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_waddr = '0;
    issue_lat   = '0;
  endtask

  // Predict this cycle's outputs, let the edge happen, update the model.
  task automatic step();
    #1;
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_fwd(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fwd_valid[ch]           = 1'b1;
    fwd_waddr[ch*AW +: AW]  = a;
    fwd_wdata[ch*DW +: DW]  = d;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({inst_out, rdata1, rdata2, stallreq} !== e) begin
        bad++;
        $display("FAIL sb t=%0t: got inst=%0h r1=%0h r2=%0h st=%0b want inst=%0h r1=%0h r2=%0h st=%0b",
                 $time, inst_out, rdata1, rdata2, stallreq,
                 e[EW-1 -: DW], e[2*DW -: DW], e[DW -: DW], e[0]);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    m_hold_v    = 1'b0;
    m_hold_inst = '0;
    rst     = 1'b1;
    inst_in = 32'h0000_0001;
    set_idle();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Reset state: no stall, instruction and operands pass straight through.
    raddr1 = 5'd3; use1 = 1'b1; rf_rdata1 = 32'h1111_2222; issue_valid = 1'b1;
    #1;
    chk("reset_stall", {31'd0, stallreq}, 32'd0);
    chk("reset_inst", inst_out, inst_in);
    chk("reset_rdata", rdata1, 32'h1111_2222);
    step();

    // Load-use interlock released by the MEM channel.
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = 5'd2;
    issue_lat = CW'(clip_lat(LAT_LOAD, MAXLAT));
    inst_in = 32'h8C82_0000;
    step();
    inst_in = 32'h0044_1821;
    issue_waddr = 5'd3; issue_lat = CW'(LAT_ALU);
    raddr1 = 5'd2; use1 = 1'b1; raddr2 = 5'd4; use2 = 1'b1;
    rf_rdata1 = 32'h0BAD_0002; rf_rdata2 = 32'h0000_0004;
    #1;
    chk("lu_stall", {31'd0, stallreq}, 32'd1);
    step();
    step();
    set_fwd(FWD_MEM, 5'd2, 32'hCAFE_0002);
    #1;
    chk("lu_release", {31'd0, stallreq}, 32'd0);
    chk("lu_bypass", rdata1, 32'hCAFE_0002);
    chk("lu_inst_held", inst_out, 32'h0044_1821);
    step();

    // Youngest channel wins.
    set_idle();
    issue_valid = 1'b1;
    raddr1 = 5'd5; use1 = 1'b1; raddr2 = 5'd5; use2 = 1'b1;
    set_fwd(FWD_EX, 5'd5, 32'h0000_AAAA);
    set_fwd(FWD_WB, 5'd5, 32'h0000_5555);
    #1;
    chk("prio_r1", rdata1, 32'h0000_AAAA);
    chk("prio_r2", rdata2, 32'h0000_AAAA);
    chk("prio_stall", {31'd0, stallreq}, 32'd0);
    step();

    // Instruction hold across an external stall.
    set_idle();
    inst_in = 32'h8C82_0004; stall_ext = 1'b1; issue_valid = 1'b1;
    step();
    inst_in = 32'hDEAD_BEEF;
    #1;
    chk("hold_keep", inst_out, 32'h8C82_0004);
    step();
    step();
    stall_ext = 1'b0;
    #1;
    chk("hold_last", inst_out, 32'h8C82_0004);
    step();
    #1;
    chk("hold_follow", inst_out, 32'hDEAD_BEEF);

    // r0 is never pending and never forwarded.
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = 5'd0; issue_lat = 2'd3;
    step();
    issue_we = 1'b0;
    raddr1 = 5'd0; use1 = 1'b1;
    set_fwd(FWD_EX, 5'd0, 32'h0000_1234);
    #1;
    chk("r0_rdata", rdata1, 32'd0);
    chk("r0_stall", {31'd0, stallreq}, 32'd0);
    step();

    // Flush mid-stall: hold cleared, counter keeps running.
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = 5'd7; issue_lat = 2'd3;
    step();
    issue_we = 1'b0; raddr1 = 5'd7; use1 = 1'b1; inst_in = 32'h0007_0001;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; inst_in = 32'h0007_0002;
    #1;
    chk("flush_hold_clr", inst_out, 32'h0007_0002);
    chk("flush_still_busy", {31'd0, stallreq}, 32'd1);
    step();
    #1;
    chk("flush_cnt_done", {31'd0, stallreq}, 32'd0);
    step();

    // Reset mid-operation.
    set_idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = 5'd9; issue_lat = 2'd3;
    step();
    issue_we = 1'b0; raddr1 = 5'd9; use1 = 1'b1; inst_in = 32'h0009_0001;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; inst_in = 32'h0009_0002;
    #1;
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_inst", inst_out, 32'h0009_0002);
    step();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall_ext   = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      inst_in     = $urandom;
      raddr1      = AW'($urandom_range(0, 7));
      raddr2      = AW'($urandom_range(0, 7));
      use1        = $urandom_range(0, 1) == 1;
      use2        = $urandom_range(0, 1) == 1;
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      fwd_valid   = NFWD'($urandom_range(0, 7) & $urandom_range(0, 7));
      for (int i = 0; i < NFWD; i++) begin
        fwd_waddr[i*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_wdata[i*DW +: DW] = $urandom;
      end
      issue_valid = $urandom_range(0, 3) != 0;
      issue_we    = $urandom_range(0, 1) == 1;
      issue_waddr = AW'($urandom_range(0, 7));
      issue_lat   = CW'($urandom_range(0, 3));
      step();
    end

    set_idle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
